// File: rtl/seg_pipe_adder.sv
// seg_pipe_adder
// Segmented, pipelined two-operand adder/subtractor with a valid/ready stream
// interface. Operands are registered in stage 0. Each of the SEGS adder stages
// then adds one SW-bit slice and passes its carry to the next stage. The last
// stage register holds the result, widened to OUT_WIDTH.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   nRST       : asynchronous active-low reset
//   in_valid   : A/B/sub are valid this cycle
//   in_ready   : the block accepts a transfer this cycle
//   A, B       : unsigned operands, WIDTH bits
//   sub        : 0 selects A+B, 1 selects A-B
//   out_valid  : Result holds a valid operation result
//   out_ready  : downstream accepts Result this cycle
//   Result     : zero-extended sum, or sign-extended (WIDTH+1)-bit difference
//
// Flow control is a single global stall. All stages advance together or all
// stages hold. Bubbles are never collapsed.
module seg_pipe_adder #(
    parameter int WIDTH     = 32,
    parameter int SEGS      = 4,
    parameter int OUT_WIDTH = 40
) (
    input  logic                 clk,
    input  logic                 nRST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic                 sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] Result
);

    localparam int SW = WIDTH / SEGS;

    // Index i holds pipeline stage i (0 = input register, 1..SEGS-1 = adder
    // stages). The final adder stage is the output register res_q/out_vld_q.
    logic [SEGS-1:0]  vld_q, vld_d;
    logic [SEGS-1:0]  sub_q, sub_d;
    logic [SEGS-1:0]  cy_q, cy_d;
    logic [WIDTH-1:0] opa_q [SEGS];
    logic [WIDTH-1:0] opa_d [SEGS];
    logic [WIDTH-1:0] opb_q [SEGS];
    logic [WIDTH-1:0] opb_d [SEGS];
    logic [WIDTH-1:0] sum_q [SEGS];
    logic [WIDTH-1:0] sum_d [SEGS];

    logic                 out_vld_q, out_vld_d;
    logic [OUT_WIDTH-1:0] res_q, res_d;

    logic                 adv_s;
    logic [SW:0]          slice_s;
    logic [SW:0]          fin_s;
    logic [WIDTH-1:0]     fin_sum_s;
    logic [WIDTH:0]       raw_s;

    // Global advance: move the pipeline when the output slot is empty or is being drained.
    always_comb begin
        adv_s = out_ready | ~out_vld_q;
    end

    assign in_ready  = adv_s;
    assign out_valid = out_vld_q;
    assign Result    = res_q;

    // Next-state for every stage; each adder stage adds one slice of its predecessor's operands.
    always_comb begin
        vld_d     = '0;
        sub_d     = '0;
        cy_d      = '0;
        slice_s   = '0;
        for (int i = 0; i < SEGS; i++) begin
            opa_d[i] = '0;
            opb_d[i] = '0;
            sum_d[i] = '0;
        end

        // B is inverted up front. The carry-in of 1 completes the two's
        // complement of B.
        vld_d[0] = in_valid;
        sub_d[0] = sub;
        cy_d[0]  = sub;
        opa_d[0] = A;
        if (sub) begin
            opb_d[0] = ~B;
        end else begin
            opb_d[0] = B;
        end
        sum_d[0] = '0;

        for (int i = 1; i < SEGS; i++) begin
            slice_s = {1'b0, opa_q[i-1][(i-1)*SW +: SW]}
                    + {1'b0, opb_q[i-1][(i-1)*SW +: SW]}
                    + {{SW{1'b0}}, cy_q[i-1]};
            vld_d[i] = vld_q[i-1];
            sub_d[i] = sub_q[i-1];
            cy_d[i]  = slice_s[SW];
            opa_d[i] = opa_q[i-1];
            opb_d[i] = opb_q[i-1];
            sum_d[i] = sum_q[i-1];
            sum_d[i][(i-1)*SW +: SW] = slice_s[SW-1:0];
        end

        // The final stage adds the top slice. It then forms the widened result
        // directly, so the output register holds its final value.
        fin_s = {1'b0, opa_q[SEGS-1][(SEGS-1)*SW +: SW]}
              + {1'b0, opb_q[SEGS-1][(SEGS-1)*SW +: SW]}
              + {{SW{1'b0}}, cy_q[SEGS-1]};
        fin_sum_s = sum_q[SEGS-1];
        fin_sum_s[(SEGS-1)*SW +: SW] = fin_s[SW-1:0];

        // For subtraction, a missing final carry means a borrow. The borrow
        // becomes the sign bit of the (WIDTH+1)-bit difference.
        if (sub_q[SEGS-1]) begin
            raw_s = {~fin_s[SW], fin_sum_s};
            res_d = OUT_WIDTH'($signed(raw_s));
        end else begin
            raw_s = {fin_s[SW], fin_sum_s};
            res_d = OUT_WIDTH'(raw_s);
        end
        out_vld_d = vld_q[SEGS-1];
    end

    // Pipeline registers: cleared by reset, loaded all together on advance, otherwise held.
    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            vld_q     <= '0;
            sub_q     <= '0;
            cy_q      <= '0;
            for (int i = 0; i < SEGS; i++) begin
                opa_q[i] <= '0;
                opb_q[i] <= '0;
                sum_q[i] <= '0;
            end
            out_vld_q <= 1'b0;
            res_q     <= '0;
        end else if (adv_s) begin
            vld_q     <= vld_d;
            sub_q     <= sub_d;
            cy_q      <= cy_d;
            opa_q     <= opa_d;
            opb_q     <= opb_d;
            sum_q     <= sum_d;
            out_vld_q <= out_vld_d;
            res_q     <= res_d;
        end
    end

endmodule

// File: tb/tb_seg_pipe_adder.sv
// Testbench for seg_pipe_adder. It uses the default 32/4/40 instance plus the
// 16/2/17 and 8/1/12 variants. Latency is counted in edges, with the accepting
// edge counted as the first edge.
module tb_seg_pipe_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        nRST;
    logic        in_valid, in_ready, sub, out_valid, out_ready;
    logic [31:0] a_in, b_in;
    logic [39:0] result;

    logic        w16_in_valid, w16_in_ready, w16_sub, w16_out_valid, w16_out_ready;
    logic [15:0] w16_a, w16_b;
    logic [16:0] w16_result;

    logic        w8_in_valid, w8_in_ready, w8_sub, w8_out_valid, w8_out_ready;
    logic [7:0]  w8_a, w8_b;
    logic [11:0] w8_result;

    int checks = 0;
    int errors = 0;

    seg_pipe_adder dut (
        .clk(clk), .nRST(nRST), .in_valid(in_valid), .in_ready(in_ready),
        .A(a_in), .B(b_in), .sub(sub), .out_valid(out_valid),
        .out_ready(out_ready), .Result(result)
    );

    seg_pipe_adder #(.WIDTH(16), .SEGS(2), .OUT_WIDTH(17)) dut_w16 (
        .clk(clk), .nRST(nRST), .in_valid(w16_in_valid), .in_ready(w16_in_ready),
        .A(w16_a), .B(w16_b), .sub(w16_sub), .out_valid(w16_out_valid),
        .out_ready(w16_out_ready), .Result(w16_result)
    );

    seg_pipe_adder #(.WIDTH(8), .SEGS(1), .OUT_WIDTH(12)) dut_w8 (
        .clk(clk), .nRST(nRST), .in_valid(w8_in_valid), .in_ready(w8_in_ready),
        .A(w8_a), .B(w8_b), .sub(w8_sub), .out_valid(w8_out_valid),
        .out_ready(w8_out_ready), .Result(w8_result)
    );

    // Reference: exact arithmetic in 40 bits. The difference wraps modulo 2^40,
    // which equals the sign-extended (WIDTH+1)-bit difference.
    function automatic logic [39:0] ref_result(input logic [31:0] a, input logic [31:0] b,
                                               input logic s);
        if (s) return {8'h00, a} - {8'h00, b};
        else   return {8'h00, a} + {8'h00, b};
    endfunction

    // Sends one op on an otherwise empty default pipeline and measures its latency.
    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s,
                          output int lat, output logic [39:0] res);
        @(negedge clk);
        a_in = a; b_in = b; sub = s; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 in_valid = 1'b0;
        res = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (out_valid === 1'b1) begin
                res = result;
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic run_w16(input logic [15:0] a, input logic [15:0] b, input logic s,
                           output int lat, output logic [16:0] res);
        @(negedge clk);
        w16_a = a; w16_b = b; w16_sub = s; w16_in_valid = 1'b1; w16_out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 w16_in_valid = 1'b0;
        res = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (w16_out_valid === 1'b1) begin
                res = w16_result;
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic run_w8(input logic [7:0] a, input logic [7:0] b, input logic s,
                          output int lat, output logic [11:0] res);
        @(negedge clk);
        w8_a = a; w8_b = b; w8_sub = s; w8_in_valid = 1'b1; w8_out_ready = 1'b1;
        @(posedge clk);
        lat = 1;
        #1 w8_in_valid = 1'b0;
        res = '0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (w8_out_valid === 1'b1) begin
                res = w8_result;
                break;
            end
            @(posedge clk);
            lat++;
        end
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        in_valid = 1'b0; a_in = '0; b_in = '0; sub = 1'b0; out_ready = 1'b1;
        w16_in_valid = 1'b0; w16_a = '0; w16_b = '0; w16_sub = 1'b0; w16_out_ready = 1'b1;
        w8_in_valid = 1'b0; w8_a = '0; w8_b = '0; w8_sub = 1'b0; w8_out_ready = 1'b1;
        #3;
        checks++;
        if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        checks++;
        if (result !== 40'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        checks++;
        if (w16_out_valid !== 1'b0 || w8_out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_variants_valid got %b/%b want 0/0", w16_out_valid, w8_out_valid);
        end
        repeat (2) @(negedge clk);
        nRST = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL post_reset got valid=%b ready=%b want 0/1", out_valid, in_ready);
        end
    endtask

    task automatic test_carry_ripple();
        int lat;
        logic [39:0] res;
        run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, lat, res);
        checks++;
        if (res !== 40'h01_0000_0000) begin errors++; $display("FAIL carry_ripple_result got %h want 0100000000", res); end
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL carry_ripple_latency got %0d want 5", lat); end
    endtask

    task automatic test_subtract();
        logic [31:0] ta [4];
        logic [31:0] tb [4];
        logic [39:0] te [4];
        int lat;
        logic [39:0] res;
        ta[0] = 32'd5;          tb[0] = 32'd7;          te[0] = 40'hFF_FFFF_FFFE;
        ta[1] = 32'd0;          tb[1] = 32'hFFFF_FFFF;  te[1] = 40'hFF_0000_0001;
        ta[2] = 32'd7;          tb[2] = 32'd5;          te[2] = 40'h00_0000_0002;
        ta[3] = 32'h1234_5678;  tb[3] = 32'h1234_5678;  te[3] = 40'h00_0000_0000;
        for (int k = 0; k < 4; k++) begin
            run_op(ta[k], tb[k], 1'b1, lat, res);
            checks++;
            if (res !== te[k]) begin errors++; $display("FAIL sub_%0d_result got %h want %h", k, res, te[k]); end
            checks++;
            if (lat !== 5) begin errors++; $display("FAIL sub_%0d_latency got %0d want 5", k, lat); end
        end
    endtask

    task automatic test_stream_backpressure();
        logic [39:0] q [$];
        logic [39:0] exp;
        logic [39:0] held_val;
        logic        held;
        logic        acc_in, acc_out;
        int          sent, got, cyc;
        sent = 0; got = 0; held = 1'b0; held_val = '0;
        for (cyc = 0; cyc < 400 && got < 16; cyc++) begin
            @(negedge clk);
            if (held) begin
                checks++;
                if (out_valid !== 1'b1 || result !== held_val) begin
                    errors++;
                    $display("FAIL stall_hold got valid=%b result=%h want 1/%h", out_valid, result, held_val);
                end
            end
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = (sent < 16) && ($urandom_range(0, 2) != 0);
            a_in      = $urandom;
            b_in      = $urandom;
            sub       = $urandom_range(0, 1) == 1;
            #1;
            checks++;
            if (in_ready !== (out_ready | ~out_valid)) begin
                errors++;
                $display("FAIL in_ready_rule got %b want %b", in_ready, out_ready | ~out_valid);
            end
            acc_in  = in_valid && in_ready;
            acc_out = out_valid && out_ready;
            if (acc_out) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL stream_extra got %h want no result", result);
                end else begin
                    exp = q.pop_front();
                    if (result !== exp) begin
                        errors++; $display("FAIL stream_result_%0d got %h want %h", got, result, exp);
                    end
                end
                got++;
            end
            if (acc_in) begin
                q.push_back(ref_result(a_in, b_in, sub));
                sent++;
            end
            held     = out_valid && !out_ready;
            held_val = result;
        end
        checks++;
        if (got !== 16) begin errors++; $display("FAIL stream_count got %0d want 16", got); end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (8) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || q.size() != 0) begin
            errors++; $display("FAIL stream_drain got valid=%b pending=%0d want 0/0", out_valid, q.size());
        end
    endtask

    task automatic test_reset_midflight();
        int lat;
        logic [39:0] res;
        logic stale;
        @(negedge clk);
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; a_in = 32'd100 + k; b_in = 32'd3; sub = 1'b0;
            @(negedge clk);
        end
        in_valid = 1'b0;
        for (int n = 0; n < 10; n++) begin
            if (out_valid === 1'b1) break;
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b1 || result !== 40'd103) begin
            errors++; $display("FAIL midflight_first got valid=%b result=%h want 1/%h", out_valid, result, 40'd103);
        end
        #2 nRST = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || result !== 40'h0) begin
            errors++; $display("FAIL async_reset got valid=%b result=%h want 0/0", out_valid, result);
        end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("FAIL async_reset_ready got %b want 1", in_ready); end
        @(negedge clk);
        nRST = 1'b1;
        out_ready = 1'b1;
        stale = 1'b0;
        for (int n = 0; n < 8; n++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) stale = 1'b1;
        end
        checks++;
        if (stale) begin errors++; $display("FAIL stale_after_reset got valid=1 want 0"); end
        run_op(32'd1, 32'd2, 1'b0, lat, res);
        checks++;
        if (res !== 40'd3) begin errors++; $display("FAIL post_reset_op_result got %h want 3", res); end
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL post_reset_op_latency got %0d want 5", lat); end
    endtask

    task automatic test_variants();
        int lat;
        logic [16:0] r16;
        logic [11:0] r8;
        run_w16(16'hFFFF, 16'hFFFF, 1'b0, lat, r16);
        checks++;
        if (r16 !== 17'h1FFFE) begin errors++; $display("FAIL w16_add got %h want 1fffe", r16); end
        checks++;
        if (lat !== 3) begin errors++; $display("FAIL w16_latency got %0d want 3", lat); end
        run_w16(16'h0000, 16'h0001, 1'b1, lat, r16);
        checks++;
        if (r16 !== 17'h1FFFF) begin errors++; $display("FAIL w16_sub got %h want 1ffff", r16); end
        run_w8(8'hFF, 8'h01, 1'b0, lat, r8);
        checks++;
        if (r8 !== 12'h100) begin errors++; $display("FAIL w8_add got %h want 100", r8); end
        checks++;
        if (lat !== 2) begin errors++; $display("FAIL w8_latency got %0d want 2", lat); end
        run_w8(8'h00, 8'h01, 1'b1, lat, r8);
        checks++;
        if (r8 !== 12'hFFF) begin errors++; $display("FAIL w8_sub got %h want fff", r8); end
    endtask

    initial begin
        test_reset();
        test_carry_ripple();
        test_subtract();
        test_stream_backpressure();
        test_reset_midflight();
        test_variants();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

endmodule
